// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, digit record type and scan-state encoding.
// Segment patterns are active-low {g,f,e,d,c,b,a}; the decimal point is handled by the caller.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] EN_OFF  = 8'hFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } digit_t;

  localparam digit_t DIGIT_RST = '{value: 4'h0, dp: 1'b0, blank: 1'b1};

  // Digit 0 is leftmost and owns en[7].
  function automatic logic [7:0] digit_en(input logic [2:0] idx);
    logic [7:0] w_onehot;
    w_onehot = 8'h80 >> idx;
    return ~w_onehot;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Register-writer and display-pin bundle for the 7-seg scan controller.
// The master side is the system writer/pin observer; the slave side is the controller.
interface seg7_scan_ctrl_if;

  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic [3:0] brightness;
  logic [7:0] dataout;
  logic [7:0] en;
  logic       frame_tick;

  modport master (
    output enable, wr_en, wr_addr, wr_data, wr_dp, wr_blank, brightness,
    input  dataout, en, frame_tick
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, wr_dp, wr_blank, brightness,
    output dataout, en, frame_tick
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low a..g segment pattern, purely combinational.
// Decimal point is not part of this decode.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_8;
    case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_8;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 8-digit common-anode scan controller: digit regfile, guard/show slot FSM, 16-level PWM.
// Pins are registered, so they follow the internal state by one cycle.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 65536,
  parameter int GUARD_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);

  digit_t           r_regs [8];
  digit_t           r_lat;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [3:0]       r_pwm;
  logic [7:0]       r_dataout;
  logic [7:0]       r_en;
  logic             r_frame_tick;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_running;
  logic             w_wrap;
  logic             w_latch;
  logic             w_show;
  logic             w_lit;
  logic [6:0]       w_seg;

  seg7_hex_decode u_dec (
    .i_hex (r_lat.value),
    .o_seg (w_seg)
  );

  always_comb begin
    w_running   = (r_state != ST_IDLE);
    w_wrap      = w_running && (r_cnt == CNT_MAX);
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_state_nxt = ST_IDLE;
    if (bus.enable) begin
      if (w_running && !w_wrap) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      if (w_wrap) begin
        w_idx_nxt = r_idx + 3'd1;
      end
      w_state_nxt = (w_cnt_nxt < CNT_GUARD) ? ST_GUARD : ST_SHOW;
    end else begin
      w_idx_nxt = 3'd0;
    end
    // The slot content is frozen on entry to the show phase.
    w_latch = bus.enable && (w_cnt_nxt == CNT_GUARD);
    w_show  = bus.enable && (r_state == ST_SHOW);
    w_lit   = w_show && !r_lat.blank && (r_pwm <= bus.brightness);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= DIGIT_RST;
      end
    end else if (bus.wr_en) begin
      r_regs[bus.wr_addr] <= '{value: bus.wr_data, dp: bus.wr_dp, blank: bus.wr_blank};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_pwm   <= 4'd0;
      r_lat   <= DIGIT_RST;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_pwm   <= r_pwm + 4'd1;
      if (w_latch) begin
        r_lat <= r_regs[w_idx_nxt];
      end
    end
  end

  // An aborted frame (enable low on the last cycle) must not pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dataout    <= SEG_OFF;
      r_en         <= EN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_dataout    <= w_show ? {~r_lat.dp, w_seg} : SEG_OFF;
      r_en         <= w_lit ? digit_en(r_idx) : EN_OFF;
      r_frame_tick <= bus.enable && w_wrap && (r_idx == 3'd7);
    end
  end

  assign bus.dataout    = r_dataout;
  assign bus.en         = r_en;
  assign bus.frame_tick = r_frame_tick;

endmodule
